// File: rtl/parity_arbiter.sv
// parity_arbiter: round-robin arbiter sharing one parity checker among N_REQ requesters,
// returning tagged pass/fail responses plus a saturating error count and sticky error flags.
module parity_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 4,
    parameter int ODD_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_parity,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic                       resp_err,
    output logic [7:0]                 err_cnt,
    output logic [N_REQ-1:0]           err_flags,
    input  logic                       clr_err
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, sel_q, sel_d, id_q, id_d, sel, idx;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d, err_q, err_d, any, bump;
    logic [7:0]        cnt_q, cnt_d;
    logic [N_REQ-1:0]  flags_q, flags_d;

    // Scan downward so the lowest offset from ptr+1 is the last (winning) match.
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        par_d   = par_q;
        id_d    = id_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (any) begin
                state_d = CHECK;
                sel_d   = sel;
                data_d  = req_data[int'(sel)*DATA_W +: DATA_W];
                par_d   = req_parity[sel];
            end
            CHECK: begin
                state_d = RESP;
                id_d    = sel_q;
                err_d   = ^data_q ^ par_q ^ (ODD_MODE != 0);
            end
            RESP: if (resp_ready) begin
                state_d = IDLE;
                ptr_d   = id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error in the same cycle as a clear survives the clear.
    assign bump    = (state_q == RESP) && resp_ready && err_q;
    assign cnt_d   = clr_err ? (bump ? 8'd1 : 8'd0)
                   : (bump && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    assign flags_d = (clr_err ? '0 : flags_q) | (bump ? ONE << id_q : '0);

    assign req_ready  = (rst_n && state_q == IDLE && any) ? ONE << sel : '0;
    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_err   = err_q;
    assign err_cnt    = cnt_q;
    assign err_flags  = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            sel_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            par_q   <= par_d;
            id_q    <= id_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: randomized self-checking bench for parity_arbiter against a
// behavioural round-robin / parity / error-count reference model.
module tb_parity_arbiter;
    localparam int N = 4, W = 4, ODD = 0;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_parity = '0, req_ready, err_flags;
    logic [N*W-1:0] req_data = '0;
    logic resp_valid, resp_ready = 1'b0, resp_err, clr_err = 1'b0;
    logic [1:0] resp_id;
    logic [7:0] err_cnt;

    int total = 0, bad = 0, cyc = 0;
    int m_ptr = N - 1, m_cnt = 0;
    logic [N-1:0] m_flags = '0;

    int o_grant, o_gcyc;
    logic o_to, o_rv1, o_rdy1, o_rv, o_stable, o_err;
    logic [1:0] o_id;
    logic [7:0] o_cnt;
    logic [N-1:0] o_flags, o_nready;

    parity_arbiter #(.N_REQ(N), .DATA_W(W), .ODD_MODE(ODD)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_parity(req_parity), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_err(resp_err),
        .err_cnt(err_cnt), .err_flags(err_flags), .clr_err(clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic exp_err(input logic [N*W-1:0] d, input logic [N-1:0] p, input int i);
        logic [W-1:0] w;
        int ones;
        w = d[i*W +: W];
        ones = $countones(w) + int'(p[i]);
        return (ones % 2) != ODD;
    endfunction

    task automatic model_commit(input int i, input logic e, input logic clr);
        if (clr) begin m_cnt = 0; m_flags = '0; end
        if (e) begin m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; m_flags[i] = 1'b1; end
        m_ptr = i;
    endtask

    task automatic model_reset();
        m_ptr = N - 1; m_cnt = 0; m_flags = '0;
    endtask

    // Drives one full transaction from a negedge and records what the DUT showed.
    task automatic run_one(input logic [N-1:0] vld, input logic [N*W-1:0] dat, input logic [N-1:0] par,
                           input int stall, input logic [N-1:0] keep, input logic clr);
        int n = 0;
        req_valid = vld; req_data = dat; req_parity = par; resp_ready = 1'b0;
        #1;
        while (req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
        o_to = (req_ready == '0);
        o_grant = -1;
        if ($countones(req_ready) == 1)
            for (int i = 0; i < N; i++) if (req_ready[i]) o_grant = i;
        o_gcyc = cyc;
        @(negedge clk); req_valid = keep; #1;
        o_rv1 = resp_valid; o_rdy1 = |req_ready;
        @(negedge clk); #1;
        o_rv = resp_valid; o_id = resp_id; o_err = resp_err; o_stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            if (!resp_valid || resp_id !== o_id || resp_err !== o_err || req_ready !== '0) o_stable = 1'b0;
        end
        resp_ready = 1'b1; clr_err = clr;
        @(negedge clk); resp_ready = 1'b0; clr_err = 1'b0; #1;
        o_cnt = err_cnt; o_flags = err_flags; o_nready = req_ready;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; clr_err = 1'b0;
        @(negedge clk); rst_n = 1'b1; model_reset();
    endtask

    task automatic test_reset();
        #1;
        total++; if ({req_ready, resp_valid, resp_id, resp_err, err_cnt, err_flags} !== '0) begin
            bad++; $display("FAIL reset_values: got %h want 0", {req_ready, resp_valid, resp_id, resp_err, err_cnt, err_flags}); end
        @(negedge clk); rst_n = 1'b1; model_reset();
        req_valid = 4'b0100; req_data = 16'h0F00; req_parity = 4'b0100; #1;
        total++; if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL pre_reset_grant: got %b want 0100", req_ready); end
        @(negedge clk); @(negedge clk); #1;
        total++; if (resp_valid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_resp: got %b want 1", resp_valid); end
        rst_n = 1'b0; #1;
        total++; if ({req_ready, resp_valid, resp_id, resp_err, err_cnt, err_flags} !== '0) begin
            bad++; $display("FAIL midresp_reset: got %h want 0", {req_ready, resp_valid, resp_id, resp_err, err_cnt, err_flags}); end
        @(negedge clk); rst_n = 1'b1; req_valid = '0; model_reset();
        run_one(4'b1111, $urandom, $urandom, 0, 4'b0000, 1'b0);
        total++; if (o_to || o_grant !== 0) begin
            bad++; $display("FAIL post_reset_first_grant: got %0d want 0", o_grant); end
        model_commit(0, exp_err(req_data, req_parity, 0), 1'b0);
        total++; if (o_cnt !== 8'(m_cnt)) begin
            bad++; $display("FAIL post_reset_cnt: got %0d want %0d", o_cnt, m_cnt); end
        do_reset();
    endtask

    task automatic test_single();
        run_one(4'b0100, 16'h0300, 4'b0000, 0, 4'b0000, 1'b0);
        total++; if (o_grant !== 2 || o_rv1 !== 1'b0 || o_rv !== 1'b1) begin
            bad++; $display("FAIL single_timing: got grant=%0d rv1=%b rv2=%b want 2 0 1", o_grant, o_rv1, o_rv); end
        total++; if (o_id !== 2'd2 || o_err !== 1'b0) begin
            bad++; $display("FAIL single_resp: got id=%0d err=%b want 2 0", o_id, o_err); end
        model_commit(2, 1'b0, 1'b0);
        total++; if (o_cnt !== 8'd0 || o_flags !== 4'b0000) begin
            bad++; $display("FAIL single_cnt: got %0d/%b want 0/0000", o_cnt, o_flags); end
    endtask

    task automatic test_mismatch();
        run_one(4'b0010, 16'h0050, 4'b0010, 0, 4'b0000, 1'b0);
        total++; if (o_grant !== 1 || o_id !== 2'd1 || o_err !== 1'b1) begin
            bad++; $display("FAIL mismatch_resp: got grant=%0d id=%0d err=%b want 1 1 1", o_grant, o_id, o_err); end
        model_commit(1, 1'b1, 1'b0);
        total++; if (o_cnt !== 8'd1 || o_flags !== 4'b0010) begin
            bad++; $display("FAIL mismatch_cnt: got %0d/%b want 1/0010", o_cnt, o_flags); end
    endtask

    task automatic test_fairness();
        int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
        int prev = 0;
        logic [N*W-1:0] d;
        logic [N-1:0] p;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            d = $urandom; p = $urandom;
            run_one(4'b1011, d, p, 0, 4'b1011, 1'b0);
            total++; if (o_grant !== exp_seq[k] || o_grant !== exp_grant(4'b1011)) begin
                bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, o_grant, exp_seq[k]); end
            if (k > 0) begin
                total++; if (o_gcyc - prev !== 3) begin
                    bad++; $display("FAIL fair_spacing[%0d]: got %0d want 3", k, o_gcyc - prev); end
            end
            prev = o_gcyc;
            total++; if (o_err !== exp_err(d, p, exp_seq[k])) begin
                bad++; $display("FAIL fair_err[%0d]: got %b want %b", k, o_err, exp_err(d, p, exp_seq[k])); end
            model_commit(exp_seq[k], exp_err(d, p, exp_seq[k]), 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] d;
        logic [N-1:0] p;
        int g;
        d = $urandom; p = $urandom; g = exp_grant(4'b1011);
        run_one(4'b1011, d, p, 5, 4'b1011, 1'b0);
        total++; if (o_grant !== g || o_stable !== 1'b1) begin
            bad++; $display("FAIL bp_stable: got grant=%0d stable=%b want %0d 1", o_grant, o_stable, g); end
        model_commit(g, exp_err(d, p, g), 1'b0);
        total++; if (o_nready !== (4'b0001 << exp_grant(4'b1011))) begin
            bad++; $display("FAIL bp_next_grant: got %b want %b", o_nready, 4'b0001 << exp_grant(4'b1011)); end
        total++; if (o_cnt !== 8'(m_cnt) || o_flags !== m_flags) begin
            bad++; $display("FAIL bp_cnt: got %0d/%b want %0d/%b", o_cnt, o_flags, m_cnt, m_flags); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 256; k++) begin
            run_one(4'b0001, 16'h000F, 4'b0001, 0, 4'b0000, 1'b0);
            model_commit(0, 1'b1, 1'b0);
            total++; if (o_cnt !== 8'(m_cnt)) begin
                bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, o_cnt, m_cnt); end
        end
        total++; if (err_cnt !== 8'd255) begin
            bad++; $display("FAIL sat_final: got %0d want 255", err_cnt); end
    endtask

    task automatic test_clear();
        run_one(4'b1000, 16'hF000, 4'b1000, 0, 4'b0000, 1'b1);
        model_commit(3, 1'b1, 1'b1);
        total++; if (o_cnt !== 8'd1 || o_flags !== 4'b1000) begin
            bad++; $display("FAIL clear_coincide: got %0d/%b want 1/1000", o_cnt, o_flags); end
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0; #1;
        model_reset(); m_ptr = 3;
        total++; if (err_cnt !== 8'd0 || err_flags !== 4'b0000) begin
            bad++; $display("FAIL clear_idle: got %0d/%b want 0/0000", err_cnt, err_flags); end
    endtask

    task automatic test_random();
        logic [N-1:0] v, p;
        logic [N*W-1:0] d;
        logic c;
        int g;
        logic e;
        for (int k = 0; k < 60; k++) begin
            v = 4'($urandom_range(1, 15)); d = $urandom; p = $urandom;
            c = ($urandom_range(0, 7) == 0);
            g = exp_grant(v); e = exp_err(d, p, g);
            run_one(v, d, p, $urandom_range(0, 3), 4'($urandom), c);
            total++; if (o_grant !== g || o_id !== 2'(g) || o_err !== e) begin
                bad++; $display("FAIL rand_resp[%0d]: got g=%0d id=%0d err=%b want %0d %0d %b", k, o_grant, o_id, o_err, g, g, e); end
            total++; if (o_rv1 !== 1'b0 || o_rv !== 1'b1 || o_rdy1 !== 1'b0 || o_stable !== 1'b1) begin
                bad++; $display("FAIL rand_timing[%0d]: got rv1=%b rv=%b rdy1=%b st=%b want 0 1 0 1", k, o_rv1, o_rv, o_rdy1, o_stable); end
            model_commit(g, e, c);
            total++; if (o_cnt !== 8'(m_cnt) || o_flags !== m_flags) begin
                bad++; $display("FAIL rand_cnt[%0d]: got %0d/%b want %0d/%b", k, o_cnt, o_flags, m_cnt, m_flags); end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_mismatch();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
